// File: rtl/fib_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fib_alu_sequencer
//  Description : Multi-cycle controller that computes Fibonacci F(n) by
//                driving a shared combinational ALU (compare, add, increment)
//                and sampling its result at the end of every state.
//  Revision    : 1.0 - initial release
// ============================================================================
module fib_alu_sequencer #(
    parameter int N  = 32,   // datapath width, equal to the ALU width
    parameter int CW = 8     // width of the Fibonacci index n
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] n_in,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result,
    output logic          overflow,
    output logic [N-1:0]  alu_src1,
    output logic [N-1:0]  alu_src2,
    output logic [3:0]    alu_ctrl,
    input  logic [N-1:0]  alu_result
);

    // Shared ALU control encodings used by this initiator
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMP  = 3'd1,
        S_ADD  = 3'd2,
        S_INC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [N-1:0]  r_a;          // F(i)
    logic [N-1:0]  r_b;          // F(i+1)
    logic [CW-1:0] r_i;          // current index
    logic [CW-1:0] r_n;          // requested index
    logic          r_a_ovf;      // true F(i) has exceeded 2^N
    logic          r_b_ovf;      // true F(i+1) has exceeded 2^N
    logic [N-1:0]  r_result;
    logic          r_overflow;

    // An unsigned sum that wrapped is smaller than either addend
    logic          w_carry;
    assign w_carry = (alu_result < r_a);

    assign result   = r_result;
    assign overflow = r_overflow;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and ALU operand/control decode from the current state
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        alu_src1     = '0;
        alu_src2     = '0;
        alu_ctrl     = ALU_ADD;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CMP;
                end
            end
            S_CMP: begin
                busy     = 1'b1;
                alu_src1 = N'(r_i);
                alu_src2 = N'(r_n);
                alu_ctrl = ALU_SLTU;
                // i < n means another iteration is still needed
                w_state_next = alu_result[0] ? S_ADD : S_DONE;
            end
            S_ADD: begin
                busy         = 1'b1;
                alu_src1     = r_a;
                alu_src2     = r_b;
                alu_ctrl     = ALU_ADD;
                w_state_next = S_INC;
            end
            S_INC: begin
                busy         = 1'b1;
                alu_src1     = N'(r_i);
                alu_src2     = N'(1);
                alu_ctrl     = ALU_ADD;
                w_state_next = S_CMP;
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers, updated from the ALU result sampled at each state end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_i        <= '0;
            r_n        <= '0;
            r_a_ovf    <= 1'b0;
            r_b_ovf    <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= n_in;
                        r_a     <= '0;
                        r_b     <= N'(1);
                        r_i     <= '0;
                        r_a_ovf <= 1'b0;
                        r_b_ovf <= 1'b0;
                    end
                end
                S_CMP: begin
                    // Publish on the edge entering DONE so result is valid with done
                    if (!alu_result[0]) begin
                        r_result   <= r_a;
                        r_overflow <= r_a_ovf;
                    end
                end
                S_ADD: begin
                    r_a     <= r_b;
                    r_b     <= alu_result;
                    r_a_ovf <= r_b_ovf;
                    r_b_ovf <= r_b_ovf | w_carry;
                end
                S_INC: begin
                    r_i <= alu_result[CW-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fib_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fib_alu_sequencer
//  Description : Directed self-checking bench for fib_alu_sequencer with a
//                behavioural combinational ALU attached to its initiator port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_alu_sequencer;

    localparam int N  = 32;
    localparam int CW = 8;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] n_in;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic          overflow;
    logic [N-1:0]  alu_src1;
    logic [N-1:0]  alu_src2;
    logic [3:0]    alu_ctrl;
    logic [N-1:0]  alu_result;

    int n_checks = 0;
    int n_errors = 0;

    fib_alu_sequencer #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_in       (n_in),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
    );

    // Behavioural shared ALU
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_AND:  alu_result = alu_src1 & alu_src2;
            ALU_OR:   alu_result = alu_src1 | alu_src2;
            ALU_ADD:  alu_result = alu_src1 + alu_src2;
            ALU_SUB:  alu_result = alu_src1 - alu_src2;
            ALU_SLTU: alu_result = {{(N-1){1'b0}}, (alu_src1 < alu_src2)};
            default:  alu_result = '0;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Launch one computation and follow it cycle by cycle. inject_at > 0 pulses
    // start with a different index during that busy cycle; tail is the number of
    // idle cycles observed after done before returning.
    task automatic run_fib(input int n, input logic [31:0] exp_res, input logic exp_ovf,
                           input int inject_at, input int tail);
        int  dcyc;
        int  ndone;
        bit  seen;
        dcyc  = 0;
        ndone = 0;
        seen  = 1'b0;
        @(negedge clk);
        check("idle_busy", {63'd0, busy}, 64'd0);
        start = 1'b1;
        n_in  = n[CW-1:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 3 * n + 8; c++) begin
            @(negedge clk);
            if (inject_at > 0 && c == inject_at) begin
                start = 1'b1;
                n_in  = 8'd3;
            end else if (inject_at > 0 && c == inject_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (!seen) begin
                    seen = 1'b1;
                    dcyc = c;
                    check("done_cycle", 64'(c), 64'(3 * n + 2));
                    check("done_busy",  {63'd0, busy}, 64'd1);
                    check("result",     64'(result), 64'(exp_res));
                    check("overflow",   {63'd0, overflow}, {63'd0, exp_ovf});
                end
            end else if (!seen) begin
                check("run_busy", {63'd0, busy}, 64'd1);
                if ((c - 1) % 3 == 0) begin
                    check("ctrl_cmp", 64'(alu_ctrl), 64'(ALU_SLTU));
                    check("cmp_src2", 64'(alu_src2), 64'(n));
                end else begin
                    check("ctrl_add", 64'(alu_ctrl), 64'(ALU_ADD));
                end
            end else begin
                check("post_busy",   {63'd0, busy}, 64'd0);
                check("post_ctrl",   64'(alu_ctrl), 64'(ALU_ADD));
                check("hold_result", 64'(result), 64'(exp_res));
            end
            if (seen && c >= dcyc + tail) break;
        end
        check("done_seen",  {63'd0, seen}, 64'd1);
        check("done_count", 64'(ndone), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        n_in  = '0;
        #3;
        check("rst_busy",     {63'd0, busy}, 64'd0);
        check("rst_done",     {63'd0, done}, 64'd0);
        check("rst_result",   64'(result), 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        check("rst_src1",     64'(alu_src1), 64'd0);
        check("rst_src2",     64'(alu_src2), 64'd0);
        check("rst_ctrl",     64'(alu_ctrl), 64'(ALU_ADD));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_fib(0,  32'd0,          1'b0, 0, 2);
        run_fib(1,  32'd1,          1'b0, 0, 0);   // next run starts right after DONE
        run_fib(2,  32'd1,          1'b0, 0, 1);
        run_fib(10, 32'd55,         1'b0, 5, 4);   // mid-run start ignored
        run_fib(47, 32'd2971215073, 1'b0, 0, 2);
        run_fib(48, 32'd512559680,  1'b1, 0, 2);

        // Asynchronous reset in the middle of an ADD state
        @(negedge clk);
        start = 1'b1;
        n_in  = 8'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);                 // CMP
        @(negedge clk);                 // ADD
        check("pre_rst_ctrl", 64'(alu_ctrl), 64'(ALU_ADD));
        check("pre_rst_src2", 64'(alu_src2), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",     {63'd0, busy}, 64'd0);
        check("arst_done",     {63'd0, done}, 64'd0);
        check("arst_result",   64'(result), 64'd0);
        check("arst_overflow", {63'd0, overflow}, 64'd0);
        check("arst_src1",     64'(alu_src1), 64'd0);
        check("arst_src2",     64'(alu_src2), 64'd0);
        check("arst_ctrl",     64'(alu_ctrl), 64'(ALU_ADD));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_hold_done", {63'd0, done}, 64'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_idle", {63'd0, busy | done}, 64'd0);
        end

        run_fib(5, 32'd5, 1'b0, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
